// File: rtl/mem_model_apb_requester.sv
// APB requester (manager) BFM: turns single command-port requests into APB transfers,
// one outstanding at a time, with an optional PREADY wait timeout.
//
// state  | meaning
// IDLE   | bus idle, cmd_ready high, command captured on handshake
// SETUP  | psel=1, penable=0, always exactly one cycle
// ACCESS | psel=1, penable=1, waiting for pready or the wait limit
module mem_model_apb_requester #(
  parameter int ADDRWIDTH = 32,
  parameter int DATAWIDTH = 32,
  parameter int TIMEOUT   = 256
) (
  input  logic                   pclk,
  input  logic                   presetn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [ADDRWIDTH-1:0]   cmd_addr,
  input  logic [DATAWIDTH-1:0]   cmd_wdata,
  input  logic [DATAWIDTH/8-1:0] cmd_strb,
  input  logic [2:0]             cmd_prot,
  output logic                   rsp_valid,
  output logic [DATAWIDTH-1:0]   rsp_rdata,
  output logic                   rsp_err,
  output logic                   rsp_timeout,
  output logic                   psel,
  output logic                   penable,
  output logic                   pwrite,
  output logic [ADDRWIDTH-1:0]   paddr,
  output logic [DATAWIDTH-1:0]   pwdata,
  output logic [DATAWIDTH/8-1:0] pstrb,
  output logic [2:0]             pprot,
  input  logic [DATAWIDTH-1:0]   prdata,
  input  logic                   pready,
  input  logic                   pslverr
);

  localparam int STRBWIDTH = DATAWIDTH / 8;
  // Keep the counter at least one bit wide so TIMEOUT=0 still elaborates.
  localparam int CNTWIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNTWIDTH-1:0] CNT_LAST = (TIMEOUT > 0) ? CNTWIDTH'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_t;

  state_t                 state, state_nxt;
  logic [CNTWIDTH-1:0]    wait_cnt, wait_cnt_nxt;
  logic                   psel_nxt, penable_nxt, pwrite_nxt;
  logic [ADDRWIDTH-1:0]   paddr_nxt;
  logic [DATAWIDTH-1:0]   pwdata_nxt;
  logic [STRBWIDTH-1:0]   pstrb_nxt;
  logic [2:0]             pprot_nxt;
  logic                   rsp_valid_nxt, rsp_err_nxt, rsp_timeout_nxt;
  logic [DATAWIDTH-1:0]   rsp_rdata_nxt;
  logic                   timeout_hit;

  assign cmd_ready   = (state == ST_IDLE);
  // wait_cnt counts completed wait cycles, so it equals TIMEOUT-1 in the TIMEOUT-th ACCESS cycle.
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_LAST);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      pstrb       <= '0;
      pprot       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      psel        <= psel_nxt;
      penable     <= penable_nxt;
      pwrite      <= pwrite_nxt;
      paddr       <= paddr_nxt;
      pwdata      <= pwdata_nxt;
      pstrb       <= pstrb_nxt;
      pprot       <= pprot_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      rsp_err     <= rsp_err_nxt;
      rsp_timeout <= rsp_timeout_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    wait_cnt_nxt    = wait_cnt;
    psel_nxt        = psel;
    penable_nxt     = penable;
    pwrite_nxt      = pwrite;
    paddr_nxt       = paddr;
    pwdata_nxt      = pwdata;
    pstrb_nxt       = pstrb;
    pprot_nxt       = pprot;
    rsp_valid_nxt   = 1'b0;
    rsp_rdata_nxt   = rsp_rdata;
    rsp_err_nxt     = rsp_err;
    rsp_timeout_nxt = rsp_timeout;

    unique case (state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_nxt    = ST_SETUP;
          wait_cnt_nxt = '0;
          psel_nxt     = 1'b1;
          penable_nxt  = 1'b0;
          pwrite_nxt   = cmd_write;
          paddr_nxt    = cmd_addr;
          pwdata_nxt   = cmd_wdata;
          pstrb_nxt    = cmd_write ? cmd_strb : '0;
          pprot_nxt    = cmd_prot;
        end
      end

      ST_SETUP: begin
        state_nxt   = ST_ACCESS;
        penable_nxt = 1'b1;
      end

      ST_ACCESS: begin
        if (pready) begin
          state_nxt       = ST_IDLE;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_err_nxt     = pslverr;
          rsp_timeout_nxt = 1'b0;
          rsp_rdata_nxt   = pwrite ? '0 : prdata;
        end else if (timeout_hit) begin
          state_nxt       = ST_IDLE;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_err_nxt     = 1'b1;
          rsp_timeout_nxt = 1'b1;
          rsp_rdata_nxt   = '0;
        end else if (wait_cnt != '1) begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end

      default: begin
        state_nxt   = ST_IDLE;
        psel_nxt    = 1'b0;
        penable_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_model_apb_requester.sv
// Bench for mem_model_apb_requester: table of APB transfers against a small memory completer,
// scoreboarded responses, bus stability monitor, and hand sequences for back-to-back and reset.
module tb_mem_model_apb_requester;

  localparam int TO = 16;

  logic        pclk, presetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready, pslverr;

  mem_model_apb_requester #(.ADDRWIDTH(32), .DATAWIDTH(32), .TIMEOUT(TO)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pstrb(pstrb), .pprot(pprot), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Completer: word memory, programmable wait states, error injection, or a permanent stall.
  logic [31:0] mem [0:255];
  int  wcnt = 0;
  int  wait_req = 0;
  bit  err_mode = 1'b0;
  bit  stall = 1'b0;

  assign pready  = psel && penable && !stall && (wcnt >= wait_req);
  assign pslverr = pready && err_mode;
  assign prdata  = (pready && !pwrite && !err_mode) ? mem[paddr[9:2]] : 32'h0;

  always @(posedge pclk) begin
    if (psel && penable && !pready) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (pready && pwrite && !err_mode)
      for (int b = 0; b < 4; b++)
        if (pstrb[b]) mem[paddr[9:2]][8*b +: 8] <= pwdata[8*b +: 8];
  end

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;
    bit          err;
    bit          stall;
    logic [31:0] exp_rdata;
    bit          exp_err;
    bit          exp_to;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];

  bit          cur_write;
  logic [31:0] cur_addr, cur_wdata;
  logic [3:0]  cur_strb;
  logic [2:0]  cur_prot;
  int          psel_cnt = 0;

  // Bus monitor: address phase stable through SETUP+ACCESS, penable only after one SETUP cycle.
  always @(negedge pclk) begin
    if (presetn) begin
      if (psel) begin
        chk("paddr_stable", paddr, cur_addr);
        chk("pwrite_stable", {31'b0, pwrite}, {31'b0, cur_write});
        chk("pstrb_stable", {28'b0, pstrb}, {28'b0, (cur_write ? cur_strb : 4'h0)});
        chk("pprot_stable", {29'b0, pprot}, {29'b0, cur_prot});
        if (cur_write) chk("pwdata_stable", pwdata, cur_wdata);
        chk("penable_phase", {31'b0, penable}, {31'b0, (psel_cnt != 0)});
        psel_cnt++;
      end else begin
        chk("penable_idle", {31'b0, penable}, 32'h0);
        psel_cnt = 0;
      end
    end
  end

  always @(negedge pclk) begin
    exp_t e;
    if (presetn && rsp_valid) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", {31'b0, rsp_valid}, 32'h0);
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        chk("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, e.to});
        chk("rsp_latency", cyc - e.acc, e.lat);
      end
    end
  end

  task automatic issue(input vec_t v);
    exp_t e;
    int n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge pclk);
      n++;
    end
    chk("issue_ready", {31'b0, cmd_ready}, 32'h1);
    wait_req  = v.waits;
    err_mode  = v.err;
    stall     = v.stall;
    cur_write = v.write;
    cur_addr  = v.addr;
    cur_wdata = v.wdata;
    cur_strb  = v.strb;
    cur_prot  = v.prot;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_strb  = v.strb;
    cmd_prot  = v.prot;
    cmd_valid = 1'b1;
    @(posedge pclk);
    #1;
    cmd_valid = 1'b0;
    // Scramble the command bus while busy; the requester must ignore it.
    cmd_write = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cmd_strb  = 4'($urandom);
    cmd_prot  = 3'($urandom);
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    e.to    = v.exp_to;
    e.acc   = cyc;
    e.lat   = v.stall ? (TO + 1) : (2 + v.waits);
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge pclk);
      n++;
    end
    chk("drain", sb.size(), 0);
    sb.delete();
  endtask

  vec_t vecs[12];
  vec_t v;

  initial begin
    bit got;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    presetn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; cmd_prot = '0;
    cur_write = 1'b0; cur_addr = '0; cur_wdata = '0; cur_strb = '0; cur_prot = '0;

    //            wr    addr          wdata         strb  prot  wt  err   stall rdata         err   to
    vecs[0]  = '{1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 3'd0, 0,  1'b0, 1'b0, 32'h0,         1'b0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_1000, 32'h0,         4'hF, 3'd2, 0,  1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_1000, 32'h1122_3344, 4'h3, 3'd1, 1,  1'b0, 1'b0, 32'h0,         1'b0, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 3'd0, 2,  1'b0, 1'b0, 32'hDEAD_3344, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_1004, 32'hA5A5_A5A5, 4'hC, 3'd5, 0,  1'b0, 1'b0, 32'h0,         1'b0, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_1004, 32'hFFFF_FFFF, 4'hF, 3'd7, 3,  1'b0, 1'b0, 32'hA5A5_0000, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_1008, 32'h5566_7788, 4'hF, 3'd0, 0,  1'b1, 1'b0, 32'h0,         1'b1, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_1008, 32'h0,         4'hF, 3'd0, 0,  1'b0, 1'b0, 32'h0,         1'b0, 1'b0};
    vecs[8]  = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 3'd3, 15, 1'b0, 1'b0, 32'hDEAD_3344, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_1000, 32'h9999_9999, 4'hF, 3'd0, 0,  1'b0, 1'b1, 32'h0,         1'b1, 1'b1};
    vecs[10] = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 3'd0, 0,  1'b0, 1'b0, 32'hDEAD_3344, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 3'd0, 0,  1'b1, 1'b0, 32'h0,         1'b1, 1'b0};

    repeat (2) @(negedge pclk);
    chk("rst_psel", {31'b0, psel}, 32'h0);
    chk("rst_penable", {31'b0, penable}, 32'h0);
    chk("rst_pwrite", {31'b0, pwrite}, 32'h0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_pstrb", {28'b0, pstrb}, 32'h0);
    chk("rst_pprot", {29'b0, pprot}, 32'h0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
    chk("rst_rsp_timeout", {31'b0, rsp_timeout}, 32'h0);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'h1);
    presetn = 1'b1;
    repeat (2) @(negedge pclk);

    for (int i = 0; i < 12; i++) issue(vecs[i]);
    drain();

    // Error response values persist after the pulse.
    repeat (3) @(negedge pclk);
    chk("hold_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("hold_rsp_err", {31'b0, rsp_err}, 32'h1);
    chk("hold_rsp_timeout", {31'b0, rsp_timeout}, 32'h0);

    // Next command accepted in the rsp_valid cycle of an erroring read.
    v = '{1'b0, 32'h0000_1000, 32'h0, 4'h0, 3'd0, 0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0};
    issue(v);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge pclk);
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk("b2b_rsp_seen", {31'b0, got}, 32'h1);
    chk("b2b_cmd_ready", {31'b0, cmd_ready}, 32'h1);
    v = '{1'b1, 32'h0000_1004, 32'h0000_BEEF, 4'h3, 3'd0, 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    issue(v);
    v = '{1'b0, 32'h0000_1004, 32'h0, 4'h0, 3'd0, 1, 1'b0, 1'b0, 32'hA5A5_BEEF, 1'b0, 1'b0};
    issue(v);
    drain();
    repeat (2) @(negedge pclk);
    chk("hold_rsp_rdata", rsp_rdata, 32'hA5A5_BEEF);

    // Reset in the middle of a stalled ACCESS: bus drops at once, no response.
    v = '{1'b1, 32'h0000_1010, 32'h1234_5678, 4'hF, 3'd0, 0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b1};
    issue(v);
    repeat (4) @(negedge pclk);
    chk("pre_rst_penable", {31'b0, penable}, 32'h1);
    #2 presetn = 1'b0;
    #1;
    chk("midrst_psel", {31'b0, psel}, 32'h0);
    chk("midrst_penable", {31'b0, penable}, 32'h0);
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    end
    presetn = 1'b1;
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      chk("postrst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    end
    v = '{1'b1, 32'h0000_1010, 32'hCAFE_F00D, 4'hF, 3'd4, 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    issue(v);
    v = '{1'b0, 32'h0000_1010, 32'h0, 4'h0, 3'd0, 0, 1'b0, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0};
    issue(v);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=%0d required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
